// File: rtl/nested_counter.sv
// Two-level loop counter: walks an inner/outer index pair up to run-time limits
// captured at start, with stall, synchronous abort and one-shot/continuous modes.
module nested_counter #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             hold,
  input  logic             mode,
  input  logic [IN_W-1:0]  inner_limit,
  input  logic [OUT_W-1:0] outer_limit,
  output logic [IN_W-1:0]  inner_cnt,
  output logic [OUT_W-1:0] outer_cnt,
  output logic             inner_last,
  output logic             outer_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IN_W-1:0]    in_lim;
  logic [OUT_W-1:0]   out_lim;
  logic               mode_q;
  logic               inner_at;
  logic               outer_at;

  // Counters only ever increment while below their limit, so no wrap is possible.
  assign inner_at   = (inner_cnt == in_lim);
  assign outer_at   = (outer_cnt == out_lim);
  assign inner_last = busy & inner_at;
  assign outer_last = busy & outer_at;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_lim    <= '0;
      out_lim   <= '0;
      mode_q    <= 1'b0;
      inner_cnt <= '0;
      outer_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      inner_cnt <= '0;
      outer_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            in_lim    <= inner_limit;
            out_lim   <= outer_limit;
            mode_q    <= mode;
            inner_cnt <= '0;
            outer_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          // A held cycle never produces done; the pulse is only set on a terminal advance.
          done <= 1'b0;
          if (!hold) begin
            if (!inner_at) begin
              inner_cnt <= inner_cnt + IN_W'(1);
            end else if (!outer_at) begin
              inner_cnt <= '0;
              outer_cnt <= outer_cnt + OUT_W'(1);
            end else begin
              inner_cnt <= '0;
              outer_cnt <= '0;
              done      <= 1'b1;
              if (!mode_q) begin
                busy  <= 1'b0;
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nested_counter.sv
// Self-checking bench for nested_counter: vector table, directed latency/reset
// sequences and a randomized run against a position-based reference model.
module tb_nested_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, clear = 1'b0, hold = 1'b0, mode = 1'b0;
  logic [3:0] inner_limit = '0, outer_limit = '0;
  logic [3:0] inner_cnt, outer_cnt;
  logic       inner_last, outer_last, busy, done;

  int checks = 0;
  int errors = 0;

  nested_counter #(.IN_W(4), .OUT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .hold(hold),
    .mode(mode), .inner_limit(inner_limit), .outer_limit(outer_limit),
    .inner_cnt(inner_cnt), .outer_cnt(outer_cnt), .inner_last(inner_last),
    .outer_last(outer_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 run, 2 done; pos is the linear index within a pass.
  int m_phase = 0, m_pos = 0, m_il = 0, m_ol = 0, m_mode = 0;
  bit m_done = 1'b0;

  function automatic void model_reset();
    m_phase = 0; m_pos = 0; m_il = 0; m_ol = 0; m_mode = 0; m_done = 1'b0;
  endfunction

  function automatic void model_step();
    int total;
    total = (m_il + 1) * (m_ol + 1);
    if (clear) begin
      m_phase = 0; m_pos = 0; m_done = 1'b0;
    end else if (m_phase == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_il = int'(inner_limit); m_ol = int'(outer_limit); m_mode = int'(mode);
        m_pos = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_done = 1'b0;
      if (!hold) begin
        if (m_pos == total - 1) begin
          m_pos = 0; m_done = 1'b1;
          if (m_mode == 0) m_phase = 2;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end else begin
      m_phase = 0; m_done = 1'b0;
    end
  endfunction

  function automatic logic [11:0] model_out();
    logic b;
    int i, o;
    b = (m_phase == 1);
    i = b ? m_pos % (m_il + 1) : 0;
    o = b ? m_pos / (m_il + 1) : 0;
    return {b, m_done, b && (i == m_il), b && (o == m_ol), 4'(o), 4'(i)};
  endfunction

  function automatic logic [11:0] dut_out();
    return {busy, done, inner_last, outer_last, outer_cnt, inner_cnt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {busy,done,il,ol,out,in}=%h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic c, input logic h, input logic m,
                       input logic [3:0] il, input logic [3:0] ol);
    @(negedge clk);
    start = s; clear = c; hold = h; mode = m; inner_limit = il; outer_limit = ol;
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_out(), model_out());
  endtask

  typedef struct {
    logic s, c, h, m;
    logic [3:0] il, ol;
    logic b, d, ila, ola;
    logic [3:0] inn, out;
  } vec_t;

  function automatic vec_t mk(logic s, logic c, logic h, logic m, logic [3:0] il, logic [3:0] ol,
                              logic b, logic d, logic ila, logic ola, logic [3:0] inn, logic [3:0] out);
    vec_t v;
    v.s = s; v.c = c; v.h = h; v.m = m; v.il = il; v.ol = ol;
    v.b = b; v.d = d; v.ila = ila; v.ola = ola; v.inn = inn; v.out = out;
    return v;
  endfunction

  // One sequence from IDLE; optionally holds hold_n cycles at pair (hi,ho). Returns cycles to done.
  task automatic run_oneshot(input logic [3:0] il, input logic [3:0] ol,
                             input logic [3:0] hi, input logic [3:0] ho,
                             input int hold_n, output int lat);
    int hcnt;
    bit seen;
    hcnt = 0; lat = 0; seen = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, il, ol);
    tick("os_start");
    for (int k = 0; k < 400 && !seen; k++) begin
      logic h;
      h = (inner_cnt == hi) && (outer_cnt == ho) && busy && (hcnt < hold_n);
      if (h) hcnt++;
      drive(1'b0, 1'b0, h, 1'b0, 4'hf, 4'hf);
      tick("os_run");
      lat++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL os_timeout: no done within budget, lat=%0d", lat);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    tick("os_back_idle");
  endtask

  vec_t tbl[18];
  int   lat_a, lat_b;

  initial begin
    tbl[0]  = mk(1,0,0,0,4'd1,4'd1, 1,0,0,0,4'd0,4'd0);
    tbl[1]  = mk(0,0,0,0,4'd1,4'd1, 1,0,1,0,4'd1,4'd0);
    tbl[2]  = mk(1,0,0,0,4'd3,4'd3, 1,0,0,1,4'd0,4'd1);
    tbl[3]  = mk(0,0,1,0,4'd3,4'd3, 1,0,0,1,4'd0,4'd1);
    tbl[4]  = mk(0,0,0,0,4'd1,4'd1, 1,0,1,1,4'd1,4'd1);
    tbl[5]  = mk(0,0,0,0,4'd1,4'd1, 0,1,0,0,4'd0,4'd0);
    tbl[6]  = mk(1,0,0,0,4'd1,4'd1, 0,0,0,0,4'd0,4'd0);
    tbl[7]  = mk(1,1,0,0,4'd1,4'd1, 0,0,0,0,4'd0,4'd0);
    tbl[8]  = mk(1,0,0,0,4'd0,4'd0, 1,0,1,1,4'd0,4'd0);
    tbl[9]  = mk(0,0,0,0,4'd0,4'd0, 0,1,0,0,4'd0,4'd0);
    tbl[10] = mk(0,0,0,0,4'd0,4'd0, 0,0,0,0,4'd0,4'd0);
    tbl[11] = mk(1,0,0,1,4'd0,4'd1, 1,0,1,0,4'd0,4'd0);
    tbl[12] = mk(0,0,0,0,4'd0,4'd1, 1,0,1,1,4'd0,4'd1);
    tbl[13] = mk(0,0,0,0,4'd0,4'd1, 1,1,1,0,4'd0,4'd0);
    tbl[14] = mk(0,0,0,0,4'd0,4'd1, 1,0,1,1,4'd0,4'd1);
    tbl[15] = mk(0,0,1,0,4'd0,4'd1, 1,0,1,1,4'd0,4'd1);
    tbl[16] = mk(0,0,0,0,4'd0,4'd1, 1,1,1,0,4'd0,4'd0);
    tbl[17] = mk(0,0,0,0,4'd0,4'd1, 0,0,0,0,4'd0,4'd0);
    tbl[17].c = 1'b1;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", dut_out(), 12'h000);
    @(negedge clk) reset = 1'b1;
    tick("idle_after_reset");

    // Vector table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].s, tbl[i].c, tbl[i].h, tbl[i].m, tbl[i].il, tbl[i].ol);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("vec%0d", i), dut_out(),
            {tbl[i].b, tbl[i].d, tbl[i].ila, tbl[i].ola, tbl[i].out, tbl[i].inn});
      check($sformatf("vec%0d_model", i), dut_out(), model_out());
    end

    // Run lengths and hold stretch
    run_oneshot(4'd12, 4'd0, 4'hf, 4'hf, 0, lat_a);
    checks++;
    if (lat_a != 13) begin errors++; $display("FAIL len_12_0: got %0d want 13", lat_a); end
    run_oneshot(4'd2, 4'd3, 4'hf, 4'hf, 0, lat_a);
    checks++;
    if (lat_a != 12) begin errors++; $display("FAIL len_2_3: got %0d want 12", lat_a); end
    run_oneshot(4'd2, 4'd3, 4'd1, 4'd2, 3, lat_b);
    checks++;
    if (lat_b != lat_a + 3) begin errors++; $display("FAIL hold_stretch: got %0d want %0d", lat_b, lat_a + 3); end

    // Asynchronous reset mid-run
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3);
    tick("pre_reset_start");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick("pre_reset_run");
    tick("pre_reset_run2");
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset_now", dut_out(), 12'h000);
    model_reset();
    @(posedge clk);
    #1 check("async_reset_held", dut_out(), 12'h000);
    @(negedge clk) reset = 1'b1;
    tick("after_reset_idle");

    // Randomized stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] il, ol;
      il = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      ol = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)), il, ol);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nested_counter.md
# nested_counter

Parametrised two-level loop counter: the generalised successor of the 4-bit free-running counter. It generates the inner/outer index pair (e.g. input index within neuron index) that sequences the forward and backpropagation datapaths. Features:
- run-time limits captured at start
- start/done handshake
- stall input
- synchronous abort
- one-shot or continuous mode

## Interface
Parameters:
- IN_W, 4, width of inner index and inner limit
- OUT_W, 4, width of outer index and outer limit

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a new sequence; sampled only in IDLE
- clear  in  1  synchronous abort; return to IDLE
- hold  in  1  stall; freezes counters while RUN
- mode  in  1  0 = one-shot, 1 = continuous; captured at start
- inner_limit  in  IN_W  last inner index (inclusive); captured at start
- outer_limit  in  OUT_W  last outer index (inclusive); captured at start
- inner_cnt  out  IN_W  current inner index
- outer_cnt  out  OUT_W  current outer index
- inner_last  out  1  inner_cnt equals captured inner limit while busy
- outer_last  out  1  outer_cnt equals captured outer limit while busy
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the terminal index pair

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, clear=0:
  - Capture inner_limit, outer_limit and mode into internal registers.
  - Next state RUN; inner_cnt and outer_cnt load 0.
- RUN, advance cycles (hold=0, clear=0):
  - inner_last=0: inner_cnt+1.
  - inner_last=1, outer_last=0: inner_cnt->0, outer_cnt+1.
  - Terminal (inner_last & outer_last), mode=0: next DONE, counters ->0.
  - Terminal, mode=1: counters ->0, stay RUN, done pulses next cycle.
- RUN with hold=1: counters, state and flags frozen; done never generated from a held cycle.
- DONE: lasts exactly one cycle, then IDLE. start is ignored in DONE.
- start while RUN or DONE is ignored; input limit and mode changes after capture have no effect.
- clear=1 in any state:
  - next state IDLE, counters 0, done not asserted.
  - clear has priority over start, hold and terminal advance.
- Limits of 0 are legal:
  - inner_limit=0: outer advances every cycle.
  - both 0: a single index pair, then terminal.
- Counters never exceed the captured limits; no arithmetic overflow path exists.
- Reset (reset=0, asynchronous):
  - state IDLE.
  - inner_cnt=0, outer_cnt=0, busy=0, done=0, inner_last=0, outer_last=0.
  - captured limits 0, mode 0.
- Reset mid-sequence aborts immediately; no done pulse is produced.

## Timing
- Start latency: start high at edge N -> busy=1, counters (0,0) visible after edge N.
- One-shot run length with no hold: (inner_limit+1)*(outer_limit+1) RUN cycles. done=1 for exactly one cycle immediately after the last RUN cycle (DONE state), busy=0 in that cycle.
- Continuous mode:
  - done is a registered pulse in the first cycle of each new pass, coincident with counters showing (0,0).
  - busy stays 1 throughout.
- Each held cycle extends the sequence by exactly one cycle.
- inner_last and outer_last are combinational from registered counters and captured limits; they are valid in the same cycle as the index they describe.
- Earliest restart after one-shot: start in the IDLE cycle following DONE.

## Test plan
- Reset then start with inner_limit=12, outer_limit=0, mode=0:
  - inner_cnt steps 0..12 over 13 cycles.
  - done pulses once in the 14th cycle after start.
  - returns to IDLE; all outputs 0.
- inner_limit=2, outer_limit=3, mode=0:
  - sequence (0,0),(1,0),(2,0),(0,1)...(2,3): 12 pairs.
  - inner_last high on every inner index 2; outer_last high for the final 3 pairs.
- Same limits with hold high for 3 cycles at pair (1,2): pair held 4 cycles total; done arrives exactly 3 cycles later than in the unheld run.
- mode=1, limits (1,1):
  - pairs repeat (0,0),(1,0),(0,1),(1,1) indefinitely.
  - done pulses with every return to (0,0) after the first pass; busy stays 1.
  - clear -> IDLE next cycle with no done.
- Limits (0,0): exactly one RUN cycle, then done.
- Start asserted while RUN with new limits: ignored, original sequence completes.
- Start and clear asserted together in IDLE: stays IDLE.
- reset driven low mid-run (async, between edges): outputs 0 immediately, no done.
